// File: rtl/hit_scorer.sv
// Rhythm-game note judge: opens a timed window per song step, scores hits, tracks combo.
// Optional feature macro: HIT_SCORER_COMBO_BONUS_EN (hits landed on a combo of 10+ score 2).
module hit_scorer #(
    parameter logic [23:0] WINDOW    = 24'd5_000_000,
    parameter logic [9:0]  SCORE_MAX = 10'd999
) (
    input  logic       clk,
    input  logic       clear,
    input  logic       note_valid,
    input  logic [4:0] note_lanes,
    input  logic [4:0] btn,
    output logic       hit,
    output logic       miss,
    output logic [9:0] score,
    output logic [3:0] digit2,
    output logic [3:0] digit1,
    output logic [3:0] digit0,
    output logic [6:0] combo,
    output logic       window_open
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OPEN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  lanes_q, lanes_d;
    logic [23:0] cnt_q, cnt_d;
    logic [4:0]  btn_q;

    logic        hit_q, miss_q;
    logic [9:0]  score_q, score_d;
    logic [11:0] digits_q, digits_d;
    logic [6:0]  combo_q, combo_d;

    logic        press;
    logic        hit_d, miss_d;
    logic [1:0]  inc;
    logic [9:0]  headroom;
    logic [1:0]  steps;
    logic [11:0] bcd_once, bcd_twice;

    // Three-digit BCD increment with decimal carry; 999 wraps but saturation keeps us below it.
    function automatic logic [11:0] bcd_inc(input logic [11:0] d);
        logic [11:0] r;
        r = d;
        if (r[3:0] == 4'd9) begin
            r[3:0] = 4'd0;
            if (r[7:4] == 4'd9) begin
                r[7:4]  = 4'd0;
                r[11:8] = (r[11:8] == 4'd9) ? 4'd0 : r[11:8] + 4'd1;
            end else begin
                r[7:4] = r[7:4] + 4'd1;
            end
        end else begin
            r[3:0] = r[3:0] + 4'd1;
        end
        return r;
    endfunction

    // A press is any lane going 0->1 between the registered sample and the live level.
    assign press = |(btn & ~btn_q);

    // NOTE: flops use non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state_q <= IDLE;
            lanes_q <= 5'd0;
            cnt_q   <= 24'd0;
            btn_q   <= 5'd0;
        end else begin
            state_q <= state_d;
            lanes_q <= lanes_d;
            cnt_q   <= cnt_d;
            btn_q   <= btn;
        end
    end

    // NOTE: every comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        lanes_d = lanes_q;
        cnt_d   = cnt_q;
        if (note_valid) begin
            if (note_lanes != 5'd0) begin
                state_d = OPEN;
                lanes_d = note_lanes;
                cnt_d   = WINDOW - 24'd1;
            end else begin
                state_d = DONE;
            end
        end else if (state_q == OPEN) begin
            if (hit_d || miss_d) begin
                state_d = DONE;
            end else begin
                cnt_d = cnt_q - 24'd1;
            end
        end
    end

    // Judgement: a press decides first; otherwise an expired or superseded note is a miss.
    always_comb begin
        hit_d       = 1'b0;
        miss_d      = 1'b0;
        window_open = (state_q == OPEN);
        if (state_q == OPEN) begin
            if (press) begin
                hit_d  = (btn == lanes_q);
                miss_d = (btn != lanes_q);
            end else if (note_valid || cnt_q == 24'd0) begin
                miss_d = 1'b1;
            end
        end
    end

`ifdef HIT_SCORER_COMBO_BONUS_EN
    assign inc = (combo_q >= 7'd10) ? 2'd2 : 2'd1;
`else
    assign inc = 2'd1;
`endif

    // Clamp the increment to what is left below SCORE_MAX so score and BCD stay in lockstep.
    assign headroom  = SCORE_MAX - score_q;
    assign steps     = !hit_d ? 2'd0 :
                       (headroom < {8'd0, inc}) ? headroom[1:0] : inc;
    assign bcd_once  = bcd_inc(digits_q);
    assign bcd_twice = bcd_inc(bcd_once);

    always_comb begin
        score_d  = score_q + {8'd0, steps};
        digits_d = digits_q;
        combo_d  = combo_q;
        case (steps)
            2'd1:    digits_d = bcd_once;
            2'd2:    digits_d = bcd_twice;
            default: digits_d = digits_q;
        endcase
        if (hit_d) begin
            combo_d = (combo_q == 7'd99) ? 7'd99 : combo_q + 7'd1;
        end else if (miss_d) begin
            combo_d = 7'd0;
        end
    end

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            hit_q    <= 1'b0;
            miss_q   <= 1'b0;
            score_q  <= 10'd0;
            digits_q <= 12'd0;
            combo_q  <= 7'd0;
        end else begin
            hit_q    <= hit_d;
            miss_q   <= miss_d;
            score_q  <= score_d;
            digits_q <= digits_d;
            combo_q  <= combo_d;
        end
    end

    assign hit    = hit_q;
    assign miss   = miss_q;
    assign score  = score_q;
    assign digit2 = digits_q[11:8];
    assign digit1 = digits_q[7:4];
    assign digit0 = digits_q[3:0];
    assign combo  = combo_q;

endmodule
